mem32_access_ctrl: RTL and testbench

MEM32_ACCESS_CTRL -- requirements
Module: mem32_access_ctrl

---
 rtl/mem32_pkg.sv | 14 +
 rtl/resp_fifo2.sv | 47 ++++
 rtl/mem32_access_ctrl.sv | 117 +++++++++++
 tb/tb_mem32_access_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem32_pkg.sv
// Shared constants and state encoding for the 32-bit memory access controller.
package mem32_pkg;

  localparam int MEM_WORD   = 32;
  localparam int MEM_ADDR   = 16;
  localparam int FIFO_DEPTH = 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/resp_fifo2.sv
// Two-entry in-order read-response FIFO; push and pop may occur in the same cycle.
module resp_fifo2
  import mem32_pkg::*;
#(
  parameter int WORD = MEM_WORD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WORD-1:0]  push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WORD-1:0]  data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WORD-1:0]  store_q [FIFO_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // NOTE: storage is reset too, so rsp_rdata cannot leak stale or X data after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) store_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        store_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop_i) rd_ptr_q <= ~rd_ptr_q;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? store_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/mem32_access_ctrl.sv
// Single-port memory access controller: request/response port plus a zero-fill engine.
module mem32_access_ctrl
  import mem32_pkg::*;
#(
  parameter int WORD = MEM_WORD,
  parameter int ADDR = MEM_ADDR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [ADDR-1:0] req_addr,
  input  logic [WORD-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [WORD-1:0] rsp_rdata,
  input  logic            clr_start,
  input  logic [ADDR-1:0] clr_base,
  input  logic [ADDR-1:0] clr_len,
  output logic            clr_busy,
  output logic            clr_done,
  output logic [ADDR-1:0] mem_A,
  output logic            mem_W,
  output logic [WORD-1:0] mem_D,
  input  logic [WORD-1:0] mem_Q
);

  state_e           state_q, state_d;
  logic [ADDR-1:0]  ptr_q, ptr_d;
  logic [ADDR-1:0]  remaining_q, remaining_d;
  logic [ADDR-1:0]  last_addr_q;
  logic             inflight_q, read_issue;
  logic             done_q, done_d;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W:0]   credits_used;

  // Credits come from registered state only, so rsp_ready never reaches req_ready.
  assign credits_used = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight_q);
  assign req_ready    = (state_q == ST_IDLE) && !clr_start
                     && (credits_used < (CNT_W+1)'(FIFO_DEPTH));
  assign clr_busy     = (state_q == ST_CLEAR);
  assign clr_done     = done_q;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    read_issue  = 1'b0;
    mem_W       = 1'b0;
    mem_A       = last_addr_q;
    mem_D       = '0;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d     = ST_CLEAR;
          ptr_d       = clr_base;
          remaining_d = clr_len;
        end else if (req_valid && req_ready) begin
          mem_A = req_addr;
          if (req_we) begin
            mem_W = 1'b1;
            mem_D = req_wdata;
          end else begin
            read_issue = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        mem_W = 1'b1;
        mem_A = ptr_q;
        ptr_d = ptr_q + ADDR'(1);
        if (remaining_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          remaining_d = remaining_q - ADDR'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      last_addr_q <= '0;
      inflight_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      last_addr_q <= mem_A;
      inflight_q  <= read_issue;
      done_q      <= done_d;
    end
  end

  // mem_Q is valid the cycle after the read-issue edge; capture it on the following edge.
  resp_fifo2 #(.WORD(WORD)) u_resp_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (inflight_q),
    .push_data_i (mem_Q),
    .pop_i       (rsp_valid && rsp_ready),
    .valid_o     (rsp_valid),
    .data_o      (rsp_rdata),
    .count_o     (fifo_count)
  );

endmodule

// File: tb/tb_mem32_access_ctrl.sv
// Directed bench for mem32_access_ctrl with a behavioural single-port memory model.
module tb_mem32_access_ctrl;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        clr_start, clr_busy, clr_done;
  logic [15:0] clr_base, clr_len;
  logic [15:0] mem_A;
  logic        mem_W;
  logic [31:0] mem_D, mem_Q;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:65535];

  mem32_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .clr_start(clr_start), .clr_base(clr_base), .clr_len(clr_len),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .mem_A(mem_A), .mem_W(mem_W), .mem_D(mem_D), .mem_Q(mem_Q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous single-port memory: Q holds its value across write cycles.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    mem_Q = '0;
  end
  always @(posedge clk) begin
    if (mem_W) mem[mem_A] <= mem_D;
    else       mem_Q      <= mem[mem_A];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [15:0] a, input logic [31:0] d);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    #1;
    check("wr_ready", req_ready, 1);
    cyc();
    req_valid = 1'b0; req_we = 1'b0; req_wdata = '0;
  endtask

  task automatic read_word(input logic [15:0] a, input logic [31:0] exp, input string tag);
    int w;
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; rsp_ready = 1'b1;
    #1;
    check({tag, "_ready"}, req_ready, 1);
    cyc();
    req_valid = 1'b0;
    #1;
    w = 0;
    while (!rsp_valid && w < 8) begin
      cyc(); #1; w++;
    end
    check({tag, "_valid"}, rsp_valid, 1);
    check({tag, "_data"}, rsp_rdata, exp);
    cyc();
  endtask

  logic [31:0] got [$];
  logic [15:0] clr_addrs [4];
  int          idx, done_seen;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; clr_start = 1'b0; clr_base = '0; clr_len = '0;

    // Reset values
    #2;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_clr_busy", clr_busy, 0);
    check("rst_clr_done", clr_done, 0);
    check("rst_mem_W", mem_W, 0);
    check("rst_mem_A", mem_A, 0);
    check("rst_mem_D", mem_D, 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    #1;
    check("post_rst_ready", req_ready, 1);
    cyc();

    // Write then read with 2-cycle latency
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h1234; req_wdata = 32'hDEADBEEF;
    #1;
    check("w1_mem_W", mem_W, 1);
    check("w1_mem_A", mem_A, 16'h1234);
    check("w1_mem_D", mem_D, 32'hDEADBEEF);
    cyc();
    req_we = 1'b0; req_wdata = '0;
    #1;
    check("r1_ready", req_ready, 1);
    check("r1_mem_W", mem_W, 0);
    check("r1_mem_D", mem_D, 0);
    cyc();
    req_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    check("r1_lat1_valid", rsp_valid, 0);
    check("idle_mem_A", mem_A, 16'h1234);
    check("idle_mem_W", mem_W, 0);
    cyc();
    check("r1_lat2_valid", rsp_valid, 1);
    check("r1_data", rsp_rdata, 32'hDEADBEEF);
    cyc();
    check("r1_popped", rsp_valid, 0);

    // Back-to-back reads with backpressure
    for (int i = 1; i <= 4; i++) write_word(16'(i), 32'hA000_0000 + 32'(i));
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0001;
    #1; check("bb_ready1", req_ready, 1);
    cyc();
    req_addr = 16'h0002;
    #1; check("bb_ready2", req_ready, 1);
    cyc();
    req_addr = 16'h0003;
    #1; check("bb_ready3_blocked", req_ready, 0);
    cyc();
    check("bb_still_blocked", req_ready, 0);
    check("bb_head_valid", rsp_valid, 1);
    check("bb_head_data", rsp_rdata, 32'hA000_0001);
    rsp_ready = 1'b1;
    idx = 3;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      req_valid = (idx <= 4);
      req_addr  = 16'(idx);
      #1;
      if (rsp_valid) got.push_back(rsp_rdata);
      if (req_valid && req_ready) idx++;
      cyc();
    end
    req_valid = 1'b0;
    check("bb_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) check("bb_order", got[i], 32'hA000_0001 + 32'(i));

    // Zero-fill wrapping through 0xFFFF
    write_word(16'hFFFE, 32'h1111_1111);
    write_word(16'hFFFF, 32'h2222_2222);
    write_word(16'h0000, 32'h3333_3333);
    write_word(16'h0002, 32'h4444_4444);
    clr_addrs[0] = 16'hFFFE; clr_addrs[1] = 16'hFFFF;
    clr_addrs[2] = 16'h0000; clr_addrs[3] = 16'h0001;
    clr_start = 1'b1; clr_base = 16'hFFFE; clr_len = 16'd3;
    #1;
    check("clr_start_ready", req_ready, 0);
    check("clr_start_busy", clr_busy, 0);
    cyc();
    clr_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("clr_busy", clr_busy, 1);
      check("clr_mem_W", mem_W, 1);
      check("clr_mem_A", mem_A, clr_addrs[i]);
      check("clr_mem_D", mem_D, 0);
      check("clr_done_early", clr_done, 0);
      cyc();
    end
    check("clr_end_busy", clr_busy, 0);
    check("clr_done_pulse", clr_done, 1);
    cyc();
    check("clr_done_single", clr_done, 0);
    for (int i = 0; i < 4; i++) read_word(clr_addrs[i], 32'h0, "clr_read");
    read_word(16'h0002, 32'h4444_4444, "clr_untouched");

    // clr_start beats a same-cycle write
    clr_start = 1'b1; clr_base = 16'h0100; clr_len = 16'd1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0100; req_wdata = 32'h0000_0055;
    #1;
    check("prio_ready", req_ready, 0);
    check("prio_mem_W", mem_W, 0);
    cyc();
    clr_start = 1'b0;
    #1;
    check("prio_clr_A0", mem_A, 16'h0100);
    check("prio_ready_clr", req_ready, 0);
    cyc();
    check("prio_clr_A1", mem_A, 16'h0101);
    cyc();
    check("prio_done", clr_done, 1);
    check("prio_ready_after", req_ready, 1);
    check("prio_wr_A", mem_A, 16'h0100);
    check("prio_wr_D", mem_D, 32'h0000_0055);
    cyc();
    req_valid = 1'b0; req_we = 1'b0;
    read_word(16'h0100, 32'h0000_0055, "prio_read");

    // Read completes while zero-fill runs
    write_word(16'h0200, 32'hCAFE_F00D);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0200; rsp_ready = 1'b1;
    #1; check("ovl_ready", req_ready, 1);
    cyc();
    req_valid = 1'b0;
    clr_start = 1'b1; clr_base = 16'h0300; clr_len = 16'd2;
    cyc();
    clr_start = 1'b0;
    #1;
    check("ovl_busy", clr_busy, 1);
    check("ovl_rsp_valid", rsp_valid, 1);
    check("ovl_rsp_data", rsp_rdata, 32'hCAFE_F00D);
    cyc();
    check("ovl_popped", rsp_valid, 0);
    done_seen = 0;
    for (int c = 0; c < 10 && done_seen == 0; c++) begin
      if (clr_done) done_seen = 1;
      else cyc();
    end
    check("ovl_done", done_seen, 1);
    cyc();

    // Reset in the middle of a fill
    clr_start = 1'b1; clr_base = 16'h0400; clr_len = 16'd7;
    cyc();
    clr_start = 1'b0;
    cyc(); cyc();
    check("mid_busy", clr_busy, 1);
    #1; rst_n = 1'b0;
    #1;
    check("mid_rst_busy", clr_busy, 0);
    check("mid_rst_mem_W", mem_W, 0);
    check("mid_rst_mem_A", mem_A, 0);
    check("mid_rst_mem_D", mem_D, 0);
    check("mid_rst_done", clr_done, 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    #1;
    check("mid_rel_ready", req_ready, 1);
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (clr_done || clr_busy || rsp_valid) done_seen++;
      cyc();
    end
    check("mid_no_done", done_seen, 0);
    read_word(16'h0404, 32'h0, "mid_read");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
